// File: rtl/interrupt_controller_pkg.sv
// game_defs: IRQ codes and enums shared by the interrupt controller files
package game_defs;
  localparam logic [1:0] IRQ_TIMER = 2'b00;
  localparam logic [1:0] IRQ_KBD = 2'b01;
  localparam logic [1:0] IRQ_NONE = 2'b11;
  typedef enum logic [1:0] {IDLE, ASSERT, SERVICE} stateT;
  typedef enum logic {SRC_TMR, SRC_KBD} srcT;
endpackage

// File: rtl/interval_timer.sv
// interval_timer: system-timer divider producing one TICK every TIMER_DIV cycles
module interval_timer #(
  parameter int TIMER_DIV = 833333,
  parameter int TIMER_W = 20
) (
  input  logic CLK,
  input  logic RESET,
  input  logic ENABLE,
  output logic TICK
);
  localparam logic [TIMER_W-1:0] LAST = TIMER_W'(TIMER_DIV - 1);
  logic [TIMER_W-1:0] count;
  assign TICK = count == LAST;
  // divider counts 0..TIMER_DIV-1 while enabled and is parked at 0 when disabled
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) count <= '0;
    else count <= (!ENABLE || TICK) ? '0 : count + 1'b1;
endmodule

// File: rtl/interrupt_controller.sv
// interrupt_controller: arbitrates timer and keyboard interrupts onto the INT_IRQ/IACK/IEND handshake
module interrupt_controller
  import game_defs::*;
#(
  parameter int TIMER_DIV = 833333,
  parameter int TIMER_W = 20
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       ENABLE,
  input  logic       KEY_VALID,
  input  logic [7:0] KEY_CODE,
  output logic [1:0] INT_IRQ,
  input  logic       INT_IACK,
  input  logic       INT_IEND,
  output logic [7:0] KBD_KEY,
  input  logic       CLEAR_STATUS,
  output logic       OVERRUN,
  output logic       MISSED_TICK
);
  stateT state, stateNext;
  srcT sel, lastGrant;
  logic tick, timerPending, keyHoldValid, grantTmr, grantKbd;
  logic [7:0] keyHold;
  interval_timer #(.TIMER_DIV(TIMER_DIV), .TIMER_W(TIMER_W)) uIntervalTimer (
    .CLK(CLK),
    .RESET(RESET),
    .ENABLE(ENABLE),
    .TICK(tick)
  );
  // with both sources pending the one not served last wins, so neither can starve the other
  assign grantKbd = ENABLE && state == IDLE && keyHoldValid && (!timerPending || lastGrant == SRC_TMR);
  assign grantTmr = ENABLE && state == IDLE && timerPending && !grantKbd;
  assign INT_IRQ = state != ASSERT ? IRQ_NONE : sel == SRC_KBD ? IRQ_KBD : IRQ_TIMER;
  // next state: grant out of IDLE, IACK wins over IEND in ASSERT, disable parks in IDLE
  always_comb begin
    stateNext = state;
    case (state)
      IDLE: stateNext = (grantTmr || grantKbd) ? ASSERT : IDLE;
      ASSERT: stateNext = INT_IACK ? SERVICE : ASSERT;
      SERVICE: stateNext = INT_IEND ? IDLE : SERVICE;
      default: stateNext = IDLE;
    endcase
    if (!ENABLE) stateNext = IDLE;
  end
  // state register plus the granted source and keycode captured at grant time
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      state <= IDLE;
      sel <= SRC_TMR;
      lastGrant <= SRC_KBD;
      KBD_KEY <= '0;
    end else begin
      state <= stateNext;
      if (grantTmr || grantKbd) begin
        sel <= grantKbd ? SRC_KBD : SRC_TMR;
        lastGrant <= grantKbd ? SRC_KBD : SRC_TMR;
      end
      if (grantKbd) KBD_KEY <= keyHold;
    end
  // pending timer request: a new tick re-arms it even in the cycle it is granted
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) timerPending <= 1'b0;
    else timerPending <= ENABLE && (tick || (timerPending && !grantTmr));
  // one-deep key hold: refilled in the same cycle a keyboard grant empties it
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      keyHold <= '0;
      keyHoldValid <= 1'b0;
    end else begin
      if (KEY_VALID && (!keyHoldValid || grantKbd)) keyHold <= KEY_CODE;
      keyHoldValid <= KEY_VALID || (keyHoldValid && !grantKbd);
    end
  // sticky error flags: a set event outranks a simultaneous clear
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      OVERRUN <= 1'b0;
      MISSED_TICK <= 1'b0;
    end else begin
      OVERRUN <= (KEY_VALID && keyHoldValid && !grantKbd) || (OVERRUN && !CLEAR_STATUS);
      MISSED_TICK <= (ENABLE && tick && timerPending && !grantTmr) || (MISSED_TICK && !CLEAR_STATUS);
    end
endmodule

// File: doc/interrupt_controller.md
Name: interrupt_controller

Overview:
Interrupt controller that sits between the frame timer and keyboard receiver and the game processor's INT_IRQ/INT_IACK/INT_IEND port.
- Generates the periodic system-timer interrupt and latches keystrokes.
- Arbitrates between the two sources and presents one encoded request at a time.
- Holds the serviced keycode on KBD_KEY from grant until end-of-interrupt.

Parameters:
TIMER_DIV, 833333, CLK cycles per timer tick (60 Hz at 50 MHz); must be >= 2
TIMER_W, 20, width of the timer divider counter; must satisfy 2^TIMER_W > TIMER_DIV

Ports:
CLK  in  1  system clock
RESET  in  1  asynchronous, active-high reset
ENABLE  in  1  controller enable; low parks the FSM (mirrors processor ENABLE)
KEY_VALID  in  1  one-cycle strobe: new keycode on KEY_CODE
KEY_CODE  in  8  ASCII keycode, valid with KEY_VALID
INT_IRQ  out  2  request: 2'b00 timer, 2'b01 keyboard, 2'b11 none
INT_IACK  in  1  one-cycle acknowledge from processor
INT_IEND  in  1  one-cycle end-of-interrupt from processor
KBD_KEY  out  8  keycode of the granted keyboard interrupt
CLEAR_STATUS  in  1  synchronous clear of the sticky flags
OVERRUN  out  1  sticky: a keystroke was dropped
MISSED_TICK  out  1  sticky: a tick arrived while the timer was still pending

Behaviour:
- Reset (async): FSM=IDLE; INT_IRQ=2'b11; KBD_KEY=0; OVERRUN=0; MISSED_TICK=0; divider=0; timerPending=0; keyHoldValid=0; lastGrant=KBD.
- Timer: divider counts 0..TIMER_DIV-1 and wraps to 0. tick=1 when the count is TIMER_DIV-1.
  - On tick, timerPending is set at the next edge.
  - If timerPending is already 1 (and not being cleared by a grant that cycle), set MISSED_TICK instead.
  - While ENABLE=0: divider is held at 0 and timerPending is cleared.
- Keys: one-deep hold register (keyHold, keyHoldValid).
  - KEY_VALID with the hold empty, or with the hold being emptied by a keyboard grant in the same cycle: load keyHold and set keyHoldValid.
  - KEY_VALID with the hold full and no grant that cycle: the key is dropped and OVERRUN is set.
  - Keys are captured regardless of ENABLE.
- FSM states: IDLE, ASSERT, SERVICE. Source register sel ∈ {TMR, KBD}.
  - IDLE, only timer pending: sel=TMR, timerPending cleared, go to ASSERT.
  - IDLE, only key pending: sel=KBD, KBD_KEY<=keyHold, keyHoldValid cleared, go to ASSERT.
  - IDLE, both pending: grant the source that is not lastGrant (alternation). lastGrant<=sel on every grant.
  - ASSERT: INT_IRQ driven from sel (00/01), stable until INT_IACK. On INT_IACK go to SERVICE.
  - SERVICE: INT_IRQ=2'b11; KBD_KEY stays stable. On INT_IEND go to IDLE.
  - INT_IRQ is 2'b11 in IDLE and SERVICE. It is decoded from registered state only, with no combinational path from inputs.
- Latency: from the pending flag being set to INT_IRQ valid is 1 cycle. After the INT_IEND edge, a pending source is visible on INT_IRQ 1 cycle later. The processor sits in its wait state, so no request is lost.
- Spurious handshakes:
  - INT_IACK outside ASSERT is ignored.
  - INT_IEND outside SERVICE is ignored.
  - INT_IACK and INT_IEND together in ASSERT: only IACK is honoured.
- ENABLE=0: FSM forced to IDLE synchronously. An in-flight grant is abandoned and its source is not re-raised. KBD_KEY is retained.
- CLEAR_STATUS clears OVERRUN and MISSED_TICK. A set event in the same cycle wins.
- No arithmetic other than the divider increment. The divider compare uses TIMER_W-bit unsigned values.

Decomposition:
- Shared package (game_defs):
  - IRQ codes IRQ_TIMER=2'b00, IRQ_KBD=2'b01, IRQ_NONE=2'b11
  - state enum {IDLE, ASSERT, SERVICE}
  - source enum {SRC_TMR, SRC_KBD}
- Sub-module interval_timer (parameters TIMER_DIV, TIMER_W; ports CLK, RESET, ENABLE, TICK) holds the divider. The FSM, the key hold and the sticky flags stay in the top module.

Test Plan (TIMER_DIV=8):
1. Reset then ENABLE=1, no keys → INT_IRQ=00 on cycle 9 after the first counted cycle. IACK → 11. IEND → the next 00 appears at the following tick.
2. KEY_VALID with KEY_CODE=8'h77 while IDLE and no timer pending → INT_IRQ=01 after 2 cycles, KBD_KEY=8'h77 held through IACK until IEND, then INT_IRQ=11.
3. Both timer and key 8'h69 pending in IDLE with lastGrant=TMR → keyboard granted first. After IEND, the timer is granted next cycle (00).
4. During SERVICE of key 8'h73, send keys 8'h6B then 8'h20 → 8'h6B held and 8'h20 dropped, OVERRUN=1. After IEND, INT_IRQ=01 with KBD_KEY=8'h6B. CLEAR_STATUS → OVERRUN=0.
5. Do not IACK the timer for 8+ cycles → MISSED_TICK=1 and only one timer interrupt is delivered.
6. Assert RESET asynchronously mid-SERVICE → immediately INT_IRQ=11, KBD_KEY=0, flags=0. Drop ENABLE in ASSERT → IDLE next cycle and IRQ=11.
